fib_seq_ctrl: RTL and testbench

//  Sequencer that owns a two-register Fibonacci datapath: (s0, s1), s1 <= s0 + s1.

---
 rtl/fib_seq_ctrl_if.sv | 31 +++
 rtl/fib_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_fib_seq_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fib_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fib_seq_ctrl_if
// Brief    : Request/result handshake bundle for the Fibonacci sequencer.
// Revision : 1.0
// ============================================================================
interface fib_seq_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
);
  logic             start;
  logic [CNT_W-1:0] n;
  logic             req_ready;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] term;
  logic             busy;
  logic             ovf;

  modport master (
    output start, n, res_ready,
    input  req_ready, res_valid, result, term, busy, ovf
  );

  modport slave (
    input  start, n, res_ready,
    output req_ready, res_valid, result, term, busy, ovf
  );
endinterface
`default_nettype wire

// File: rtl/fib_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fib_seq_ctrl
// Brief    : Sequencer iterating a two-register Fibonacci datapath n times and
//            returning F(n). Optional macro FIB_OVF_EN enables ovf tracking.
// Revision : 1.0
// ============================================================================
module fib_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fib_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s0_q, s0_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d;

`ifdef FIB_OVF_EN
  // o0/o1 remember whether the true (untruncated) s0/s1 have exceeded WIDTH
  logic             o0_q, o0_d;
  logic             o1_q, o1_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum_w;
  assign sum_w = {1'b0, s0_q} + {1'b0, s1_q};
`else
  logic [WIDTH-1:0] sum_w;
  assign sum_w = s0_q + s1_q;
`endif

  always_comb begin
    state_d     = state_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    res_valid_d = res_valid_q;
`ifdef FIB_OVF_EN
    o0_d        = o0_q;
    o1_d        = o1_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_d   = bus.n;
          s0_d    = '0;
          s1_d    = WIDTH'(1);
`ifdef FIB_OVF_EN
          o0_d    = 1'b0;
          o1_d    = 1'b0;
          ovf_d   = 1'b0;
`endif
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          s0_d  = s1_q;
          s1_d  = sum_w[WIDTH-1:0];
          cnt_d = cnt_q - CNT_W'(1);
`ifdef FIB_OVF_EN
          o0_d  = o1_q;
          o1_d  = o0_q | o1_q | sum_w[WIDTH];
`endif
        end else begin
          result_d    = s0_q;
          res_valid_d = 1'b1;
`ifdef FIB_OVF_EN
          ovf_d       = o0_q;
`endif
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      s0_q        <= '0;
      s1_q        <= WIDTH'(1);
      cnt_q       <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
`ifdef FIB_OVF_EN
      o0_q        <= 1'b0;
      o1_q        <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
`ifdef FIB_OVF_EN
      o0_q        <= o0_d;
      o1_q        <= o1_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;
  assign bus.term      = s0_q;
`ifdef FIB_OVF_EN
  assign bus.ovf       = ovf_q;
`else
  assign bus.ovf       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fib_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_seq_ctrl
// Brief    : Self-checking bench for fib_seq_ctrl against a 64-bit Fibonacci
//            reference (ovf expectation follows FIB_OVF_EN).
// Revision : 1.0
// ============================================================================
module tb_fib_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 6;
  localparam longint unsigned MASK = (64'd1 << WIDTH) - 64'd1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  fib_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  fib_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Exact Fibonacci value, wide enough for every index CNT_W allows
  function automatic longint unsigned fib(input int k);
    longint unsigned a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic longint unsigned exp_ovf(input int k);
`ifdef FIB_OVF_EN
    return ((fib(k) >> WIDTH) != 0) ? 64'd1 : 64'd0;
`else
    return (k < 0) ? 64'd1 : 64'd0;
`endif
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, bus.req_ready, 1);
    check({pfx, "_res_valid"}, bus.res_valid, 0);
    check({pfx, "_result"},    bus.result,    0);
    check({pfx, "_term"},      bus.term,      0);
    check({pfx, "_busy"},      bus.busy,      0);
    check({pfx, "_ovf"},       bus.ovf,       0);
  endtask

  // One request/result transaction; called at posedge+1
  task automatic run_req(input int nreq, input int hold, input bit noise);
    int  k;
    bit  seen;
    longint unsigned exp_res;
    exp_res = fib(nreq) & MASK;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("req_ready_wait", bus.req_ready, 1);
    bus.start = 1'b1;
    bus.n     = CNT_W'(nreq);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("accept_busy", bus.busy, 1);
    check("accept_term", bus.term, 0);
    seen = 1'b0;
    for (int j = 1; j <= 80 && !seen; j++) begin
      if (noise) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.n         = CNT_W'($urandom);
        bus.res_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (bus.res_valid) begin
        seen = 1'b1;
        check($sformatf("latency_n%0d", nreq), longint'(j), longint'(nreq + 1));
      end else begin
        check($sformatf("term[%0d]", j), bus.term, fib(j) & MASK);
      end
    end
    check("res_valid_seen", seen, 1);
    bus.res_ready = 1'b0;
    check($sformatf("result_n%0d", nreq), bus.result, exp_res);
    check($sformatf("ovf_n%0d", nreq), bus.ovf, exp_ovf(nreq));
    check("done_term", bus.term, exp_res);
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        bus.start = 1'b1;
        bus.n     = CNT_W'($urandom);
      end
      @(posedge clk); #1;
      check("hold_valid",     bus.res_valid, 1);
      check("hold_result",    bus.result,    exp_res);
      check("hold_req_ready", bus.req_ready, 0);
    end
    bus.start     = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("drain_valid",     bus.res_valid, 0);
    check("drain_req_ready", bus.req_ready, 1);
    check("drain_busy",      bus.busy,      0);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.n         = '0;
    bus.res_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    run_req(10, 0, 1'b0);
    run_req(0,  0, 1'b0);
    run_req(1,  0, 1'b0);
    run_req(2,  0, 1'b0);
    run_req(24, 1, 1'b0);
    run_req(25, 1, 1'b0);
    run_req(7,  5, 1'b1);
    run_req(63, 2, 1'b1);
    repeat (12) run_req(int'($urandom_range(0, 63)), int'($urandom_range(0, 4)), 1'b1);

    // Abort mid-run with asynchronous reset
    bus.start = 1'b1;
    bus.n     = CNT_W'(20);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_busy", bus.busy, 1);
    check("pre_rst_term", bus.term, fib(5) & MASK);
    rst = 1'b0;
    #2;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    run_req(5, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
